relogio_alarme: RTL
===================

# relogio_alarme

Parametrised successor to the team's BCD wall clock: a 24-hour HH:MM:SS BCD timekeeper driven by an internal clock divider, with a loadable time, a loadable alarm, and an alarm state machine with timed ring and snooze. Sits between the board clock and the 7-segment display driver. Outputs are BCD digits ready for the existing decoder.

## Interface
- CLK_DIV, default 100_000_000: clk cycles per second; minimum 2.
- RING_SEC, default 30: seconds the alarm rings before self-clearing, 1..255.
- SNOOZE_MIN, default 5: snooze length in minutes, 1..59.
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high; clears all state.
- H_in1  in  2, H_in0  in  4, M_in1  in  4, M_in0  in  4  BCD load value, hours/minutes.
- LD_time  in  1  load H_in/M_in into the time registers.
- LD_alarm  in  1  load H_in/M_in into the alarm registers.
- alarm_en  in  1  alarm armed; low forces FSM to IDLE.
- snooze  in  1  level; sampled each cycle.
- disp_sel  in  1  0 = show time, 1 = show alarm setting (S digits 0).
- H_out1  out  2, H_out0, M_out1, M_out0, S_out1, S_out0  out  4 each  BCD display digits.
- tick_1s  out  1  one-cycle pulse per second.
- alarm_ring  out  1  high while FSM in RINGING.

## Operation
- Divider counts 0..CLK_DIV-1; tick_1s high on the cycle it equals CLK_DIV-1; wraps to 0.
- On tick: seconds +1; 59→00 carries to minutes; 59→00 carries to hours; 23:59:59→00:00:00.
- LD_time: if H_in ≤ 23 and M_in ≤ 59 (each digit valid BCD), load H/M, clear seconds and divider. Invalid values ignored entirely. Priority over a tick in the same cycle.
- LD_alarm: same validity rule, loads alarm H/M only. LD_time and LD_alarm together: both load.
- FSM states IDLE, RINGING, SNOOZE; ring/snooze counter in seconds (width for max(RING_SEC, SNOOZE_MIN*60)).
- IDLE→RINGING: alarm_en=1 and tick advances time to alarm HH:MM:00; counter loaded with RING_SEC.
- RINGING: counter decrements on tick; reaching 0 → IDLE. snooze=1 → SNOOZE, counter loaded SNOOZE_MIN*60.
- SNOOZE: decrements on tick; reaching 0 → RINGING, counter reloaded RING_SEC.
- alarm_en=0 in any state → IDLE next edge (overrides all other transitions).
- LD_time while RINGING/SNOOZE: FSM unaffected; loading exactly the alarm time does not trigger (trigger only on tick).
- disp_sel selects output mux; purely combinational from registers.

## Timing
- Reset values: all digits 0, divider 0, alarm 00:00, FSM IDLE, tick_1s 0, alarm_ring 0.
- Time digits update on the edge ending the tick_1s cycle (visible one cycle after tick_1s high).
- LD_time/LD_alarm take effect on the same edge they are sampled; outputs visible next cycle.
- alarm_ring rises the cycle the time shows HH:MM:00 matching alarm; falls the cycle after the RING_SEC-th subsequent tick.
- Reset asserted mid-ring: alarm_ring low immediately (async).

## Structure
- Package relogio_pkg: bcd_t (4-bit) typedef, alarm FSM state enum, MAX_H/MAX_M/MAX_S constants, BCD validity function.
- Sub-module contador_bcd: two-digit BCD counter with parameter MOD, inc, load, carry-out; instantiated for seconds (60), minutes (60), hours (24).
- Divider, FSM, alarm registers and output mux in top level.

## Test plan
- CLK_DIV=4: reset 2 cycles, release -> tick_1s every 4th cycle, S_out=01 one cycle after first tick.
- LD_time 23:59, run 60 ticks -> 23:59:59 then 00:00:00, no stray carries.
- LD_time with H_in=2,4 (24) or M_in0=10 -> outputs unchanged.
- LD_alarm 00:02, alarm_en=1, LD_time 00:01, RING_SEC=3 -> alarm_ring high at 00:02:00, low after 00:02:03.
- Same, snooze pulse at 00:02:01, SNOOZE_MIN=1 -> ring low, re-rings at 00:03:01 for 3 s; alarm_en=0 mid-ring -> low next cycle.
- Async reset during RINGING and simultaneous LD_time+tick -> all outputs 0 immediately; load wins over tick.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared types and helpers for the BCD alarm clock.
// Latency: n/a (types and functions only); backpressure: none.
package relogio_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RINGING,
        ST_SNOOZE
    } alarm_st_t;

    localparam int MAX_H = 23;
    localparam int MAX_M = 59;
    localparam int MAX_S = 59;

    // True when both digits are decimal and the pair does not exceed max_val.
    function automatic logic bcd_ok(input bcd_t hi, input bcd_t lo, input int max_val);
        return (hi <= 4'd9) && (lo <= 4'd9) && ((int'(hi) * 10 + int'(lo)) <= max_val);
    endfunction

endpackage

// File: rtl/relogio_alarme_contador_bcd.sv
// Two-digit BCD modulo-MOD counter with synchronous load and carry-out.
// Latency: 1 cycle (load/inc visible next cycle); backpressure: none.
module contador_bcd
    import relogio_pkg::*;
#(
    parameter int MOD = 60,
    parameter int W1  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          load,
    input  logic [W1-1:0] ld1,
    input  bcd_t          ld0,
    output logic [W1-1:0] q1,
    output bcd_t          q0,
    output logic [W1-1:0] nxt1,
    output bcd_t          nxt0,
    output logic          carry
);

    localparam int MAX_HI = (MOD - 1) / 10;
    localparam int MAX_LO = (MOD - 1) % 10;

    logic at_max;

    assign at_max = (q1 == W1'(MAX_HI)) && (q0 == 4'(MAX_LO));

    // Load wins over increment, and a loaded counter never carries.
    always_comb begin
        nxt1  = q1;
        nxt0  = q0;
        carry = 1'b0;
        if (load) begin
            nxt1 = ld1;
            nxt0 = ld0;
        end else if (inc) begin
            if (at_max) begin
                nxt1  = '0;
                nxt0  = '0;
                carry = 1'b1;
            end else if (q0 == 4'd9) begin
                nxt1 = q1 + W1'(1);
                nxt0 = '0;
            end else begin
                nxt0 = q0 + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q1 <= '0;
            q0 <= '0;
        end else begin
            q1 <= nxt1;
            q0 <= nxt0;
        end
    end

endmodule

// File: rtl/relogio_alarme.sv
// 24-hour BCD clock with loadable time/alarm and ring/snooze alarm FSM.
// Latency: loads and ticks visible 1 cycle later; backpressure: none.
module relogio_alarme
    import relogio_pkg::*;
#(
    parameter int CLK_DIV    = 100_000_000,
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic       LD_time,
    input  logic       LD_alarm,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       disp_sel,
    output logic [1:0] H_out1,
    output logic [3:0] H_out0,
    output logic [3:0] M_out1,
    output logic [3:0] M_out0,
    output logic [3:0] S_out1,
    output logic [3:0] S_out0,
    output logic       tick_1s,
    output logic       alarm_ring
);

    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int SNZ_SEC = SNOOZE_MIN * 60;
    localparam int CNT_MAX = (RING_SEC > SNZ_SEC) ? RING_SEC : SNZ_SEC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic             in_valid;
    logic             time_ld_ok;
    logic             alarm_ld_ok;

    logic [1:0] hr_q1, hr_nxt1, alarm_h1;
    bcd_t       hr_q0, hr_nxt0, alarm_h0;
    bcd_t       min_q1, min_q0, min_nxt1, min_nxt0, alarm_m1, alarm_m0;
    bcd_t       sec_q1, sec_q0, sec_nxt1, sec_nxt0;
    logic       sec_c, min_c;
    logic       day_wrap_unused;
    logic       trigger;

    alarm_st_t        state;
    logic [CNT_W-1:0] remain;
    logic             ring_q;

    assign tick        = (div_q == DIV_W'(CLK_DIV - 1));
    assign in_valid    = bcd_ok({2'b00, H_in1}, H_in0, MAX_H) && bcd_ok(M_in1, M_in0, MAX_M);
    assign time_ld_ok  = LD_time && in_valid;
    assign alarm_ld_ok = LD_alarm && in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (time_ld_ok || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    contador_bcd #(.MOD(MAX_S + 1), .W1(4)) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (tick),
        .load  (time_ld_ok),
        .ld1   (4'd0),
        .ld0   (4'd0),
        .q1    (sec_q1),
        .q0    (sec_q0),
        .nxt1  (sec_nxt1),
        .nxt0  (sec_nxt0),
        .carry (sec_c)
    );

    contador_bcd #(.MOD(MAX_M + 1), .W1(4)) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_c),
        .load  (time_ld_ok),
        .ld1   (M_in1),
        .ld0   (M_in0),
        .q1    (min_q1),
        .q0    (min_q0),
        .nxt1  (min_nxt1),
        .nxt0  (min_nxt0),
        .carry (min_c)
    );

    // Midnight rollover needs no action beyond the hour counter wrapping.
    contador_bcd #(.MOD(MAX_H + 1), .W1(2)) u_hr (
        .clk   (clk),
        .reset (reset),
        .inc   (min_c),
        .load  (time_ld_ok),
        .ld1   (H_in1),
        .ld0   (H_in0),
        .q1    (hr_q1),
        .q0    (hr_q0),
        .nxt1  (hr_nxt1),
        .nxt0  (hr_nxt0),
        .carry (day_wrap_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_h1 <= '0;
            alarm_h0 <= '0;
            alarm_m1 <= '0;
            alarm_m0 <= '0;
        end else if (alarm_ld_ok) begin
            alarm_h1 <= H_in1;
            alarm_h0 <= H_in0;
            alarm_m1 <= M_in1;
            alarm_m0 <= M_in0;
        end
    end

    // Fires only when a genuine tick rolls the time onto HH:MM:00 of the alarm;
    // a load that lands exactly on the alarm time does not count.
    assign trigger = tick && !time_ld_ok
                  && (sec_nxt1 == 4'd0) && (sec_nxt0 == 4'd0)
                  && (min_nxt1 == alarm_m1) && (min_nxt0 == alarm_m0)
                  && (hr_nxt1 == alarm_h1) && (hr_nxt0 == alarm_h0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            remain <= '0;
            ring_q <= 1'b0;
        end else if (!alarm_en) begin
            state  <= ST_IDLE;
            ring_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state  <= ST_RINGING;
                        remain <= CNT_W'(RING_SEC);
                        ring_q <= 1'b1;
                    end
                end
                ST_RINGING: begin
                    if (snooze) begin
                        state  <= ST_SNOOZE;
                        remain <= CNT_W'(SNZ_SEC);
                        ring_q <= 1'b0;
                    end else if (tick) begin
                        if (remain <= CNT_W'(1)) begin
                            state  <= ST_IDLE;
                            ring_q <= 1'b0;
                        end else begin
                            remain <= remain - CNT_W'(1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (tick) begin
                        if (remain <= CNT_W'(1)) begin
                            state  <= ST_RINGING;
                            remain <= CNT_W'(RING_SEC);
                            ring_q <= 1'b1;
                        end else begin
                            remain <= remain - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    ring_q <= 1'b0;
                end
            endcase
        end
    end

    assign tick_1s    = tick;
    assign alarm_ring = ring_q;

    always_comb begin
        if (disp_sel) begin
            H_out1 = alarm_h1;
            H_out0 = alarm_h0;
            M_out1 = alarm_m1;
            M_out0 = alarm_m0;
            S_out1 = 4'd0;
            S_out0 = 4'd0;
        end else begin
            H_out1 = hr_q1;
            H_out0 = hr_q0;
            M_out1 = min_q1;
            M_out0 = min_q0;
            S_out1 = sec_q1;
            S_out0 = sec_q0;
        end
    end

endmodule
